// File: rtl/clk_switch_ctrl.sv
// Clock-source switch sequencer for a glitch-free clock mux. It confirms the target clock
// is toggling, moves `select`, then waits out the mux handover before acknowledging.

module clk_switch_ctrl #(
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned ALIVE_WINDOW  = 64,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic req_sel,
  input  logic clk0_in,
  input  logic clk1_in,
  output logic select,
  output logic busy,
  output logic ack,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SWITCH,
    DONE,
    FAIL
  } state_t;

  localparam logic [CNT_W-1:0] EDGE_GOAL   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(ALIVE_WINDOW - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  state_t           state, state_n;
  logic             target, target_n;
  logic             select_n;
  logic [CNT_W-1:0] win_cnt, win_n;
  logic [CNT_W-1:0] edge_cnt, edges_n;

  // Bit 0 follows clk0_in, bit 1 follows clk1_in.
  logic [1:0] src_meta, src_sync, src_prev;
  logic [1:0] src_edge;
  logic       target_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // NOTE: the source clocks are plain data here; two flops settle metastability
  // before the edge detector looks at them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_meta <= '0;
      src_sync <= '0;
      src_prev <= '0;
    end else begin
      src_meta <= {clk1_in, clk0_in};
      src_sync <= src_meta;
      src_prev <= src_sync;
    end
  end

  assign src_edge    = src_sync ^ src_prev;
  assign target_edge = target ? src_edge[1] : src_edge[0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    target_n = target;
    select_n = select;
    win_n    = win_cnt;
    edges_n  = edge_cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_sel == select) begin
            state_n = DONE;
          end else begin
            state_n  = CHECK;
            target_n = req_sel;
            win_n    = '0;
            edges_n  = '0;
          end
        end
      end
      CHECK: begin
        // Enough edges wins even when the window expires in the same cycle.
        if (edge_cnt >= EDGE_GOAL) begin
          state_n  = SWITCH;
          select_n = target;
          win_n    = '0;
          edges_n  = '0;
        end else if (win_cnt >= WIN_LAST) begin
          state_n = FAIL;
        end else begin
          win_n = sat_inc(win_cnt);
          if (target_edge) edges_n = sat_inc(edge_cnt);
        end
      end
      SWITCH: begin
        if (win_cnt >= SETTLE_LAST) state_n = DONE;
        else                        win_n   = sat_inc(win_cnt);
      end
      DONE:    state_n = IDLE;
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= 1'b0;
      select   <= 1'b0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      select   <= select_n;
      win_cnt  <= win_n;
      edge_cnt <= edges_n;
      busy     <= (state_n == CHECK) || (state_n == SWITCH);
      ack      <= (state_n == DONE);
      err      <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: reset, same-source ack, dead target,
// good switch timing, request while busy and reset during the settle phase.

module tb_clk_switch_ctrl;

  localparam int ALIVE_WINDOW  = 64;
  localparam int SETTLE_CYCLES = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic req     = 1'b0;
  logic req_sel = 1'b0;
  logic clk0_in = 1'b0;
  logic clk1_in = 1'b0;
  logic clk1_en = 1'b1;
  logic select, busy, ack, err;

  int checks   = 0;
  int failures = 0;

  clk_switch_ctrl #(
    .MIN_EDGES    (4),
    .ALIVE_WINDOW (ALIVE_WINDOW),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .req_sel(req_sel),
    .clk0_in(clk0_in),
    .clk1_in(clk1_in),
    .select (select),
    .busy   (busy),
    .ack    (ack),
    .err    (err)
  );

  // 100 MHz reference, ~13.9 MHz clk0, 10 MHz clk1 that can be stopped low.
  always #5 clk = ~clk;
  always #36 clk0_in = ~clk0_in;
  always begin
    #50;
    clk1_in = clk1_en ? ~clk1_in : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    int errs;

    // Reset defaults while the reference clock runs.
    repeat (3) tick();
    check("rst_select", select, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (select || busy || ack || err) n++;
    end
    check("idle_quiet", n, 0);

    // Same source: immediate ack, no busy.
    req = 1'b1; req_sel = 1'b0;
    tick();
    check("same0_ack", ack, 1);
    check("same0_busy", busy, 0);
    check("same0_select", select, 0);
    req = 1'b0;
    tick();
    check("same0_ack_pulse", ack, 0);

    // Dead target: busy for exactly ALIVE_WINDOW cycles, then one err.
    clk1_en = 1'b0;
    repeat (10) tick();
    req = 1'b1; req_sel = 1'b1;
    tick();
    check("dead_busy_rise", busy, 1);
    req = 1'b0;
    n = 1; acks = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      acks += int'(ack);
      if (!busy) break;
      n++;
    end
    check("dead_busy_len", n, ALIVE_WINDOW);
    check("dead_err", err, 1);
    check("dead_select", select, 0);
    check("dead_no_ack", acks, 0);
    tick();
    check("dead_err_pulse", err, 0);

    // Good switch to clk1.
    clk1_en = 1'b1;
    repeat (5) tick();
    req = 1'b1; req_sel = 1'b1;
    tick();
    check("good_busy_rise", busy, 1);
    req = 1'b0;
    n = 0; errs = 0;
    while (!select && n < ALIVE_WINDOW) begin
      tick();
      n++;
      errs += int'(err);
    end
    check("good_select", select, 1);
    n = 0;
    while (!ack && n < 40) begin
      tick();
      n++;
      errs += int'(err);
    end
    check("good_ack_delay", n, SETTLE_CYCLES + 1);
    check("good_busy_with_ack", busy, 0);
    tick();
    check("good_ack_pulse", ack, 0);
    check("good_no_err", errs, 0);

    // Same source while already on clk1.
    req = 1'b1; req_sel = 1'b1;
    tick();
    check("same1_ack", ack, 1);
    check("same1_select", select, 1);
    req = 1'b0;
    tick();

    // Asynchronous reset returns select to 0 without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_select", select, 0);
    check("async_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // A second request during CHECK is ignored; exactly one ack.
    req = 1'b1; req_sel = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    check("busy2_in_check", busy, 1);
    check("busy2_select_hold", select, 0);
    req = 1'b1; req_sel = 1'b0;
    tick();
    req = 1'b0;
    acks = 0; errs = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      acks += int'(ack);
      errs += int'(err);
    end
    check("busy2_one_ack", acks, 1);
    check("busy2_select", select, 1);
    check("busy2_no_err", errs, 0);

    // Reset five cycles into SWITCH: no ack afterwards.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 1'b1; req_sel = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (!select && n < ALIVE_WINDOW) begin
      tick();
      n++;
    end
    check("midrst_select_up", select, 1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_select", select, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ack", ack, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      acks += int'(ack);
    end
    check("midrst_no_ack", acks, 0);
    check("midrst_select_after", select, 0);
    check("midrst_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
Sequencer that produces the `select` input of the glitch-free clock mux, which sits directly downstream. It runs on an always-on reference clock and accepts a source-switch request over a req/ack handshake. Before moving `select`, it confirms the target clock is toggling, then holds off acknowledging until the mux has had time to complete its two-domain handover. It never requests a switch to a dead clock, so the mux cannot hang with both enables low.

Parameters:
MIN_EDGES, 4, synchronized target-clock transitions (either edge) required to declare the target alive.
ALIVE_WINDOW, 64, maximum reference cycles spent in CHECK before declaring the target dead.
SETTLE_CYCLES, 16, reference cycles to wait after driving `select` before acknowledging; must cover the mux handover.
CNT_W, 8, width of the internal window/settle counter; must hold max(ALIVE_WINDOW, SETTLE_CYCLES).

Ports:
clk  input  1  always-on reference clock; must be faster than 2x the frequency of clk0_in and of clk1_in.
rst_n  input  1  asynchronous active-low reset.
req  input  1  switch request; sampled only in IDLE.
req_sel  input  1  requested source, sampled with req: 0 = clk0, 1 = clk1.
clk0_in  input  1  mux source 0, sampled as data for liveness only.
clk1_in  input  1  mux source 1, sampled as data for liveness only.
select  output  1  drives the mux select; registered.
busy  output  1  high while a request is in progress.
ack  output  1  one-cycle pulse: the switch completed, or no switch was needed.
err  output  1  one-cycle pulse: target clock is dead and select is unchanged.

Behaviour:
- Reset (async assert, sync release): state = IDLE, select = 0, busy = 0, ack = 0, err = 0, counters = 0, synchronizer flops = 0.
- Liveness path:
  - Each clkN_in passes through a 2-flop synchronizer, then a 1-flop edge detector (XOR of the last two synchronized samples).
  - Edges are counted only in CHECK, and only for the target source.
- FSM states: IDLE, CHECK, SWITCH, DONE, FAIL.
- IDLE:
  - If req=1 and req_sel==select: go to DONE. ack pulses on the next cycle; busy stays 0; select is unchanged.
  - If req=1 and req_sel!=select: latch the target, clear the counters, busy=1 from the next cycle, go to CHECK.
- CHECK:
  - The window counter increments every cycle; the edge counter increments on each target edge.
  - If the edge count reaches MIN_EDGES, go to SWITCH immediately (early exit). This takes priority if it coincides with window expiry.
  - Else, if the window counter reaches ALIVE_WINDOW-1, go to FAIL.
- SWITCH:
  - On entry, select <= target (registered, changes exactly once per request).
  - Count SETTLE_CYCLES cycles, then go to DONE.
- DONE: ack=1 for exactly one cycle, busy=0 in that same cycle, then go to IDLE.
- FAIL: err=1 for exactly one cycle, busy=0 in that same cycle, select unchanged, then go to IDLE.
- Requests:
  - req while busy is ignored; there is no queueing. The requester must hold req until ack or err, or re-issue it.
  - req held high across ack is treated as a new request on the first IDLE cycle. A same-source request then acks again.
- ack and err are never high in the same cycle. busy, ack and err are all registered outputs.
- Counters saturate and never wrap. Counters are cleared on entry to CHECK and to SWITCH.
- rst_n asserted mid-operation: all outputs return immediately to their reset values. select returns to 0 even if a switch was in progress.
- Minimum latency for a good switch: 1 (accept) + MIN_EDGES-dependent CHECK time + SETTLE_CYCLES + 1 (DONE) cycles.

Test Plan:
- Reset default: hold rst_n=0, toggle clk -> select=0, busy=0, ack=0, err=0. Release reset, idle for 20 cycles -> outputs unchanged.
- Good switch (clk=100 MHz, clk1_in=10 MHz, defaults):
  - Stimulus: req=1, req_sel=1 for one cycle.
  - Response: busy rises next cycle, select=1 within ALIVE_WINDOW cycles.
  - Then: ack pulses exactly SETTLE_CYCLES+1 cycles after the select change, busy=0 with ack, err never high.
- Dead target: clk1_in held at 0, req_sel=1 -> busy high for ALIVE_WINDOW cycles, then a single err pulse, select stays 0, no ack.
- Same source: select=0, req_sel=0 -> ack on the cycle after req, busy never asserted, select unchanged.
- Request while busy: a second req with req_sel=0 arrives mid-CHECK of a switch to 1 -> it is ignored, the switch completes to select=1, exactly one ack.
- Reset mid-SWITCH: pull rst_n low 5 cycles after select goes to 1 -> select=0 and busy=0 asynchronously, and no ack is emitted after release.
